lcd_hex_writer: RTL and testbench

LCD_HEX_WRITER -- requirements
Module: lcd_hex_writer

---
 rtl/lcd_hex_writer.sv | 159 +++++++++++++++
 tb/tb_lcd_hex_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_writer.sv
// Prints a 32-bit value as 1..8 uppercase hex digits, optionally prefixed with "0x",
// into a 2x40 character display buffer at one character per clock.
module lcd_hex_writer (
    input  logic        iMClk,
    input  logic        iMRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqLine,
    input  logic [5:0]  iReqCol,
    input  logic [31:0] iReqValue,
    input  logic [3:0]  iReqDigits,
    input  logic        iReqPrefix,
    input  logic        iReqZs,
    output logic [6:0]  oDDAddr,
    output logic [7:0]  oDDData,
    output logic        oDDEn,
    output logic        oDone
);
    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, DONE} state_t;

    state_t      state_q;
    logic        line_q;
    logic [5:0]  col_q;
    logic [31:0] val_q;
    logic [3:0]  left_q;
    logic        lead_q;
    logic        ready_q;
    logic        en_q;
    logic        done_q;
    logic [6:0]  addr_q;
    logic [7:0]  data_q;

    logic [3:0]  req_n;
    logic [31:0] req_aligned;
    logic [5:0]  col_d;
    logic [31:0] dig_val;
    logic [3:0]  dig_left;
    logic        dig_lead;
    logic [3:0]  nib;
    logic        dig_blank;
    logic [7:0]  dig_char;
    logic [31:0] val_d;
    logic [3:0]  left_d;
    logic        lead_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // The value is left-aligned so the next digit to print is always bits [31:28].
    // In IDLE the first digit is taken straight from the request so it can be
    // written on the accepting edge.
    always_comb begin
        // NOTE: every signal gets a value on every path, otherwise a latch is inferred.
        req_n       = (iReqDigits == 4'd0 || iReqDigits > 4'd8) ? 4'd8 : iReqDigits;
        req_aligned = iReqValue << {4'd8 - req_n, 2'b00};
        col_d       = (col_q == 6'd39) ? 6'd0 : col_q + 6'd1;
        if (state_q == IDLE) begin
            dig_val  = req_aligned;
            dig_left = req_n;
            dig_lead = iReqZs;
        end else begin
            dig_val  = val_q;
            dig_left = left_q;
            dig_lead = lead_q;
        end
        nib       = dig_val[31:28];
        dig_blank = dig_lead && (nib == 4'd0) && (dig_left != 4'd1);
        dig_char  = dig_blank ? 8'h20 : hex_ascii(nib);
        val_d     = dig_val << 4;
        left_d    = dig_left - 4'd1;
        lead_d    = dig_blank;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iMClk or posedge iMRst) begin
        if (iMRst) begin
            state_q <= IDLE;
            line_q  <= 1'b0;
            col_q   <= 6'd0;
            val_q   <= 32'd0;
            left_q  <= 4'd0;
            lead_q  <= 1'b0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= 7'h00;
            data_q  <= 8'h20;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iReqValid) begin
                        ready_q <= 1'b0;
                        line_q  <= iReqLine;
                        col_q   <= iReqCol;
                        val_q   <= req_aligned;
                        left_q  <= req_n;
                        lead_q  <= iReqZs;
                        if (iReqCol >= 6'd40) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (iReqPrefix) begin
                            state_q <= PFX0;
                            en_q    <= 1'b1;
                            addr_q  <= {iReqLine, iReqCol};
                            data_q  <= 8'h30;
                        end else begin
                            state_q <= DIGIT;
                            en_q    <= 1'b1;
                            addr_q  <= {iReqLine, iReqCol};
                            data_q  <= dig_char;
                            val_q   <= val_d;
                            left_q  <= left_d;
                            lead_q  <= lead_d;
                        end
                    end
                end
                PFX0: begin
                    state_q <= PFX1;
                    en_q    <= 1'b1;
                    col_q   <= col_d;
                    addr_q  <= {line_q, col_d};
                    data_q  <= 8'h78;
                end
                PFX1, DIGIT: begin
                    if (state_q == DIGIT && left_q == 4'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DIGIT;
                        en_q    <= 1'b1;
                        col_q   <= col_d;
                        addr_q  <= {line_q, col_d};
                        data_q  <= dig_char;
                        val_q   <= val_d;
                        left_q  <= left_d;
                        lead_q  <= lead_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign oReqReady = ready_q;
    assign oDDAddr   = addr_q;
    assign oDDData   = data_q;
    assign oDDEn     = en_q;
    assign oDone     = done_q;
endmodule

// File: tb/tb_lcd_hex_writer.sv
// Self-checking bench for lcd_hex_writer: directed cases plus random requests,
// each compared cycle by cycle against a character-list model of the request.
module tb_lcd_hex_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        line;
    logic [5:0]  col;
    logic [31:0] value;
    logic [3:0]  digits;
    logic        prefix;
    logic        zs;
    logic [6:0]  dd_addr;
    logic [7:0]  dd_data;
    logic        dd_en;
    logic        done;

    int passed = 0;
    int total  = 0;

    logic [6:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [6:0] last_addr;
    logic [7:0] last_data;

    lcd_hex_writer dut (
        .iMClk      (clk),
        .iMRst      (rst),
        .iReqValid  (valid),
        .oReqReady  (ready),
        .iReqLine   (line),
        .iReqCol    (col),
        .iReqValue  (value),
        .iReqDigits (digits),
        .iReqPrefix (prefix),
        .iReqZs     (zs),
        .oDDAddr    (dd_addr),
        .oDDData    (dd_data),
        .oDDEn      (dd_en),
        .oDone      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Expected (address, character) list for one request, written as text rules.
    function automatic void build_model(input bit l, input int c, input logic [31:0] v,
                                        input int d, input bit p, input bit z);
        logic [7:0] chars[$];
        int n;
        bit seen;
        exp_addr.delete();
        exp_data.delete();
        if (c >= 40) return;
        n = (d == 0 || d > 8) ? 8 : d;
        seen = 1'b0;
        if (p) begin
            chars.push_back(8'h30);
            chars.push_back(8'h78);
        end
        for (int k = 0; k < n; k++) begin
            int nb;
            nb = int'((v >> (4 * (n - 1 - k))) & 32'hF);
            if (nb != 0) seen = 1'b1;
            if (z && !seen && k != n - 1) chars.push_back(8'h20);
            else if (nb < 10)             chars.push_back(8'(48 + nb));
            else                          chars.push_back(8'(65 + nb - 10));
        end
        foreach (chars[i]) begin
            exp_addr.push_back(7'((l ? 64 : 0) + (c + i) % 40));
            exp_data.push_back(chars[i]);
        end
    endfunction

    task automatic scramble();
        line   = 1'($urandom);
        col    = 6'($urandom);
        value  = $urandom;
        digits = 4'($urandom);
        prefix = 1'($urandom);
        zs     = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready),   32'h1);
        check({tag, "_en"},    32'(dd_en),   32'h0);
        check({tag, "_done"},  32'(done),    32'h0);
        check({tag, "_addr"},  32'(dd_addr), 32'h00);
        check({tag, "_data"},  32'(dd_data), 32'h20);
    endtask

    // Called at a falling edge; the request is accepted on the following rising edge.
    task automatic run_req(input string tag, input bit l, input logic [5:0] c,
                           input logic [31:0] v, input logic [3:0] d, input bit p,
                           input bit z, input bit stream, input int abort_after);
        int w;
        build_model(l, int'(c), v, int'(d), p, z);
        w = exp_addr.size();
        line = l; col = c; value = v; digits = d; prefix = p; zs = z; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i <= w + 1; i++) begin
            if (i == abort_after) begin
                rst   = 1'b1;
                valid = 1'b0;
                #1;
                check_reset_outputs({tag, "_abort"});
                last_addr = 7'h00;
                last_data = 8'h20;
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check({tag, "_post_en"},    32'(dd_en), 32'h0);
                    check({tag, "_post_done"},  32'(done),  32'h0);
                    check({tag, "_post_ready"}, 32'(ready), 32'h1);
                end
                return;
            end
            if (i < w) begin
                check({tag, "_en"},    32'(dd_en),   32'h1);
                check({tag, "_addr"},  32'(dd_addr), 32'(exp_addr[i]));
                check({tag, "_data"},  32'(dd_data), 32'(exp_data[i]));
                check({tag, "_busy"},  32'(ready),   32'h0);
                check({tag, "_ndone"}, 32'(done),    32'h0);
                last_addr = exp_addr[i];
                last_data = exp_data[i];
            end else begin
                check({tag, "_idle_en"}, 32'(dd_en),   32'h0);
                check({tag, "_done"},    32'(done),    32'((i == w) ? 1 : 0));
                check({tag, "_ready"},   32'(ready),   32'((i == w) ? 0 : 1));
                check({tag, "_hold_a"},  32'(dd_addr), 32'(last_addr));
                check({tag, "_hold_d"},  32'(dd_data), 32'(last_data));
            end
            if (i < w + 1) begin
                if (i == w && !stream) begin
                    valid = 1'b0;
                end else begin
                    valid = 1'b1;
                    scramble();
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        line = 1'b0; col = '0; value = '0; digits = '0; prefix = 1'b0; zs = 1'b0;
        last_addr = 7'h00;
        last_data = 8'h20;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_req("hex4",   1'b0, 6'd0,  32'h00001A2F, 4'd4, 1'b0, 1'b0, 1'b0, -1);
        run_req("pfx8",   1'b1, 6'd10, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 1'b0, -1);
        run_req("zs0",    1'b0, 6'd5,  32'h00000000, 4'd4, 1'b0, 1'b1, 1'b0, -1);
        run_req("wrap",   1'b1, 6'd38, 32'h00001234, 4'd4, 1'b0, 1'b0, 1'b0, -1);
        run_req("col45",  1'b0, 6'd45, 32'h89ABCDEF, 4'd8, 1'b1, 1'b0, 1'b0, -1);
        run_req("abort",  1'b0, 6'd3,  32'hCAFEF00D, 4'd8, 1'b0, 1'b0, 1'b0, 2);
        run_req("zspfx",  1'b1, 6'd37, 32'h000A0B00, 4'd12, 1'b1, 1'b1, 1'b0, -1);

        for (int j = 0; j < 4; j++) begin
            run_req("stream", 1'($urandom), 6'($urandom_range(0, 39)), $urandom,
                    4'($urandom), 1'($urandom), 1'($urandom), 1'b1, -1);
        end
        for (int j = 0; j < 12; j++) begin
            run_req("rand", 1'($urandom), 6'($urandom_range(0, 47)),
                    $urandom >> $urandom_range(0, 31), 4'($urandom), 1'($urandom),
                    1'($urandom), 1'b0, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
